// File: rtl/param_search_q.sv
// param_search_q: searchable flow FIFO. Entries are kept packed in arrival
// order (index 0 oldest). Supports head dequeue, single-cycle associative
// lookup, in-place data update and multi-entry delete in the same cycle.
module param_search_q #(
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 104,
    parameter int DATA_W = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic [KEY_W-1:0]  enq_key,
    input  logic [DATA_W-1:0] enq_data,
    output logic              full,
    input  logic              deq,
    output logic [KEY_W-1:0]  deq_key,
    output logic [DATA_W-1:0] deq_data,
    output logic              empty,
    output logic [CW-1:0]     count,
    input  logic              lookup,
    input  logic [KEY_W-1:0]  lookup_key,
    output logic              hit_valid,
    output logic              hit,
    output logic              hit_multi,
    output logic [DEPTH-1:0]  hit_bitmap,
    output logic [IW-1:0]     hit_idx,
    output logic [DATA_W-1:0] hit_data,
    input  logic              update,
    input  logic [DEPTH-1:0]  update_bitmap,
    input  logic [DATA_W-1:0] update_data,
    input  logic              delete,
    input  logic [DEPTH-1:0]  delete_bitmap,
    output logic              err_ovf,
    output logic              err_udf,
    output logic              err_upd
);

    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1'b1);
    localparam logic [DEPTH-1:0] ONE_D   = DEPTH'(1'b1);

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [DEPTH-1:0] v);
        return (v != '0) && ((v & (v - ONE_D)) == '0);
    endfunction

    // Stored state
    logic [KEY_W-1:0]  r_key  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [CW-1:0]     r_count;
    logic              r_err_ovf, r_err_udf, r_err_upd;
    logic              r_hit_valid, r_hit, r_hit_multi;
    logic [DEPTH-1:0]  r_hit_bitmap;
    logic [IW-1:0]     r_hit_idx;
    logic [DATA_W-1:0] r_hit_data;

    // Next-state and lookup signals
    logic [KEY_W-1:0]  w_key  [DEPTH];
    logic [DATA_W-1:0] w_data [DEPTH];
    logic [DEPTH-1:0]  w_valid;
    logic [DEPTH-1:0]  w_rm;
    logic [CW-1:0]     w_pos;
    logic              w_upd_ok;
    logic              w_err_ovf, w_err_udf, w_err_upd;
    logic [DEPTH-1:0]  w_match;
    logic [IW-1:0]     w_hit_idx;
    logic              w_hit_multi;
    logic [DATA_W-1:0] w_hit_data;

    assign empty    = (r_count == '0);
    assign full     = (r_count == DEPTH_C);
    assign count    = r_count;
    assign deq_key  = r_key[0];
    assign deq_data = r_data[0];

    assign hit_valid  = r_hit_valid;
    assign hit        = r_hit;
    assign hit_multi  = r_hit_multi;
    assign hit_bitmap = r_hit_bitmap;
    assign hit_idx    = r_hit_idx;
    assign hit_data   = r_hit_data;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;
    assign err_upd    = r_err_upd;

    // Next queue contents: update, remove, stable compaction, then append.
    always_comb begin
        w_key     = '{default: '0};
        w_data    = '{default: '0};
        w_valid   = '0;
        w_pos     = '0;
        w_err_ovf = 1'b0;
        w_upd_ok  = update && is_onehot(update_bitmap);
        w_err_upd = update && !is_onehot(update_bitmap);
        w_err_udf = deq && (r_count == '0);
        w_rm      = ((delete ? delete_bitmap : '0) |
                     ((deq && (r_count != '0)) ? ONE_D : '0)) & r_valid;

        // Survivors pack downward; w_pos is the next free slot.
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !w_rm[i]) begin
                w_valid[w_pos[IW-1:0]] = 1'b1;
                w_key[w_pos[IW-1:0]]   = r_key[i];
                w_data[w_pos[IW-1:0]]  = (w_upd_ok && update_bitmap[i]) ? update_data : r_data[i];
                w_pos                  = w_pos + ONE_C;
            end else begin
                w_pos = w_pos;
            end
        end

        if (enq) begin
            if (w_pos < DEPTH_C) begin
                w_valid[w_pos[IW-1:0]] = 1'b1;
                w_key[w_pos[IW-1:0]]   = enq_key;
                w_data[w_pos[IW-1:0]]  = enq_data;
                w_pos                  = w_pos + ONE_C;
            end else begin
                w_err_ovf = 1'b1;
            end
        end else begin
            w_err_ovf = 1'b0;
        end
    end

    // Associative compare on current state; oldest match has priority.
    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && (r_key[i] == lookup_key);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = IW'(i);
            end else begin
                w_hit_idx = w_hit_idx;
            end
        end
        w_hit_multi = ((w_match & (w_match - ONE_D)) != '0);
        w_hit_data  = (w_match != '0) ? r_data[w_hit_idx] : '0;
    end

    // Queue storage, count and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
            r_valid   <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
            r_err_upd <= 1'b0;
        end else begin
            r_key     <= w_key;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_count   <= w_pos;
            r_err_ovf <= w_err_ovf;
            r_err_udf <= w_err_udf;
            r_err_upd <= w_err_upd;
        end
    end

    // Lookup result registers; results hold until the next lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_valid  <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_multi  <= 1'b0;
            r_hit_bitmap <= '0;
            r_hit_idx    <= '0;
            r_hit_data   <= '0;
        end else begin
            r_hit_valid <= lookup;
            if (lookup) begin
                r_hit        <= (w_match != '0);
                r_hit_multi  <= w_hit_multi;
                r_hit_bitmap <= w_match;
                r_hit_idx    <= w_hit_idx;
                r_hit_data   <= w_hit_data;
            end else begin
                r_hit        <= r_hit;
                r_hit_multi  <= r_hit_multi;
                r_hit_bitmap <= r_hit_bitmap;
                r_hit_idx    <= r_hit_idx;
                r_hit_data   <= r_hit_data;
            end
        end
    end

endmodule

// File: tb/tb_param_search_q.sv
// Directed self-checking bench for param_search_q (DEPTH=8).
module tb_param_search_q;

    localparam int DEPTH = 8;
    localparam int KW    = 104;
    localparam int DW    = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enq, deq, lookup, update, delete;
    logic [KW-1:0]    enq_key, lookup_key, deq_key;
    logic [DW-1:0]    enq_data, update_data, deq_data, hit_data;
    logic [DEPTH-1:0] update_bitmap, delete_bitmap, hit_bitmap;
    logic             full, empty, hit_valid, hit, hit_multi;
    logic [3:0]       count;
    logic [2:0]       hit_idx;
    logic             err_ovf, err_udf, err_upd;

    int n_checks = 0;
    int n_fail   = 0;

    param_search_q #(.DEPTH(DEPTH), .KEY_W(KW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq(enq), .enq_key(enq_key), .enq_data(enq_data), .full(full),
        .deq(deq), .deq_key(deq_key), .deq_data(deq_data),
        .empty(empty), .count(count),
        .lookup(lookup), .lookup_key(lookup_key),
        .hit_valid(hit_valid), .hit(hit), .hit_multi(hit_multi),
        .hit_bitmap(hit_bitmap), .hit_idx(hit_idx), .hit_data(hit_data),
        .update(update), .update_bitmap(update_bitmap), .update_data(update_data),
        .delete(delete), .delete_bitmap(delete_bitmap),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_upd(err_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq = 1'b0; deq = 1'b0; lookup = 1'b0; update = 1'b0; delete = 1'b0;
        enq_key = '0; enq_data = '0; lookup_key = '0;
        update_bitmap = '0; update_data = '0; delete_bitmap = '0;
    endtask

    task automatic push(input logic [KW-1:0] k, input logic [DW-1:0] d);
        enq = 1'b1; enq_key = k; enq_data = d;
        tick();
        enq = 1'b0;
    endtask

    task automatic find(input logic [KW-1:0] k);
        lookup = 1'b1; lookup_key = k;
        tick();
        lookup = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_deq_key", deq_key, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_err", {err_ovf, err_udf, err_upd}, 0);

        // Fill A..H (keys 100..107, data 200..207)
        for (int i = 0; i < 8; i++) push(KW'(100 + i), DW'(200 + i));
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_head", deq_key, 100);

        // Overflow
        push(KW'(108), DW'(208));
        chk("ovf_pulse", err_ovf, 1);
        chk("ovf_count", count, 8);
        tick();
        chk("ovf_oneshot", err_ovf, 0);

        // deq + enq while full
        deq = 1'b1; enq = 1'b1; enq_key = KW'(108); enq_data = DW'(208);
        tick();
        idle();
        chk("deqenq_count", count, 8);
        chk("deqenq_head", deq_key, 101);
        chk("deqenq_no_ovf", err_ovf, 0);
        find(KW'(108));
        chk("lk_I_valid", hit_valid, 1);
        chk("lk_I_idx", hit_idx, 7);
        chk("lk_I_data", hit_data, 208);
        chk("lk_I_multi", hit_multi, 0);
        tick();
        chk("lk_pulse_end", hit_valid, 0);
        chk("lk_hold", hit_idx, 7);

        // Multi-delete compaction
        do_reset();
        for (int i = 0; i < 8; i++) push(KW'(100 + i), DW'(200 + i));
        delete = 1'b1; delete_bitmap = 8'b0101_0110;
        tick();
        idle();
        chk("del_count", count, 4);
        chk("del_head", deq_key, 100);
        find(KW'(101));
        chk("del_miss_hit", hit, 0);
        chk("del_miss_bmp", hit_bitmap, 0);
        chk("del_miss_data", hit_data, 0);
        find(KW'(105));
        chk("del_F_idx", hit_idx, 2);
        deq = 1'b1; tick();
        chk("drain1", deq_key, 103);
        tick();
        chk("drain2", deq_key, 105);
        chk("drain2_data", deq_data, 205);
        tick();
        chk("drain3", deq_key, 107);
        tick();
        deq = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_zero", deq_key, 0);

        // Underflow
        deq = 1'b1; tick(); deq = 1'b0;
        chk("udf_pulse", err_udf, 1);
        chk("udf_count", count, 0);

        // Multi-hit lookup: X,Y,X
        push(KW'(12'hABC), DW'(1));
        push(KW'(12'hDEF), DW'(2));
        push(KW'(12'hABC), DW'(3));
        find(KW'(12'hABC));
        chk("mh_valid", hit_valid, 1);
        chk("mh_hit", hit, 1);
        chk("mh_multi", hit_multi, 1);
        chk("mh_bmp", hit_bitmap, 8'b0000_0101);
        chk("mh_idx", hit_idx, 0);
        chk("mh_data", hit_data, 1);

        // Update + delete same entry: delete wins, no error
        update = 1'b1; update_bitmap = 8'b010; update_data = DW'(9);
        delete = 1'b1; delete_bitmap = 8'b010;
        tick();
        idle();
        chk("ud_no_err", err_upd, 0);
        chk("ud_count", count, 2);
        find(KW'(12'hDEF));
        chk("ud_gone", hit, 0);

        // Non-one-hot update
        update = 1'b1; update_bitmap = 8'b011; update_data = DW'(9);
        tick();
        idle();
        chk("upd_err", err_upd, 1);
        find(KW'(12'hABC));
        chk("upd_bad_data", hit_data, 1);
        chk("upd_bad_bmp", hit_bitmap, 8'b0000_0011);

        // Valid one-hot update
        update = 1'b1; update_bitmap = 8'b010; update_data = DW'(7);
        tick();
        idle();
        chk("upd_ok_noerr", err_upd, 0);
        find(KW'(12'hABC));
        chk("upd_ok_idx", hit_idx, 0);
        chk("upd_ok_data", hit_data, 1);
        update = 1'b1; update_bitmap = 8'b001; update_data = DW'(7);
        tick();
        idle();
        find(KW'(12'hABC));
        chk("upd_head_data", hit_data, 7);
        chk("upd_head_deq", deq_data, 7);

        // Mid-stream reset with lookup pending
        push(KW'(1), DW'(11));
        push(KW'(2), DW'(12));
        push(KW'(3), DW'(13));
        chk("mid_count5", count, 5);
        lookup = 1'b1; lookup_key = KW'(12'hABC);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_hit", hit, 0);
        chk("mid_hit_data", hit_data, 0);
        chk("mid_deq_key", deq_key, 0);
        tick();
        chk("mid_no_pulse", hit_valid, 0);
        idle();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pulse", hit_valid, 0);
        chk("post_rst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
